// File: rtl/alu_issue_stage_if.sv
// Issue-stage handshake bundle: upstream instruction,
// downstream ALU operands and the ALU writeback port.
interface alu_issue_stage_if #(
   parameter int DATA_W = 20,
   parameter int OP_W   = 20,
   parameter int AW     = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_op;
   logic [AW-1:0]     in_rd;
   logic [AW-1:0]     in_rs1;
   logic [AW-1:0]     in_rs2;
   logic              out_valid;
   logic              out_ready;
   logic [OP_W-1:0]   out_op;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;
   logic [AW-1:0]     out_rd;
   logic              wb_en;
   logic [AW-1:0]     wb_addr;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output in_valid, in_op, in_rd,
      output in_rs1, in_rs2,
      output out_ready,
      output wb_en, wb_addr, wb_data,
      input  in_ready,
      input  out_valid, out_op,
      input  out_a, out_b, out_rd
   );

   modport slave (
      input  in_valid, in_op, in_rd,
      input  in_rs1, in_rs2,
      input  out_ready,
      input  wb_en, wb_addr, wb_data,
      output in_ready,
      output out_valid, out_op,
      output out_a, out_b, out_rd
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand issue stage: register file, scoreboard
// and a registered ALU-facing output slot.
module alu_issue_stage #(
   parameter int DATA_W = 20,
   parameter int OP_W   = 20,
   parameter int NREGS  = 16,
   parameter int AW     = $clog2(NREGS)
) (
   input logic              clk,
   input logic              rst,
   alu_issue_stage_if.slave io
);
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  pend_q;
   logic [NREGS-1:0]  pend_d;
   logic [NREGS-1:0]  pend_eff;

   logic              valid_q, valid_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [AW-1:0]     rd_q, rd_d;

   logic              wb_live;
   logic              hazard;
   logic              ready;
   logic              accept;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;

   assign wb_live = io.wb_en && (io.wb_addr != '0);

   // Same-cycle writeback resolves the hazard it clears.
   always_comb begin
      pend_eff = pend_q;
      if (io.wb_en)
         pend_eff[io.wb_addr] = 1'b0;
   end

   assign hazard = pend_eff[io.in_rs1] |
                   pend_eff[io.in_rs2];
   assign ready  = (!valid_q || io.out_ready) &&
                   !hazard;
   assign accept = io.in_valid && ready;

   function automatic logic [DATA_W-1:0] rd_src(
      input logic [AW-1:0] idx
   );
      if (idx == '0)
         return '0;
      else if (wb_live && (io.wb_addr == idx))
         return io.wb_data;
      else
         return regs_q[idx];
   endfunction

   assign src_a = rd_src(io.in_rs1);
   assign src_b = rd_src(io.in_rs2);

   always_comb begin
      regs_d  = regs_q;
      pend_d  = pend_q;
      valid_d = valid_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;

      if (wb_live) begin
         regs_d[io.wb_addr] = io.wb_data;
         pend_d[io.wb_addr] = 1'b0;
      end

      // Issue-side set wins over a same-cycle clear.
      if (accept) begin
         valid_d = 1'b1;
         op_d    = io.in_op;
         a_d     = src_a;
         b_d     = src_b;
         rd_d    = io.in_rd;
         if (io.in_rd != '0)
            pend_d[io.in_rd] = 1'b1;
      end else if (valid_q && io.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
         pend_q  <= '0;
         valid_q <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
      end else begin
         regs_q  <= regs_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
      end
   end

   assign io.in_ready  = ready;
   assign io.out_valid = valid_q;
   assign io.out_op    = op_q;
   assign io.out_a     = a_q;
   assign io.out_b     = b_q;
   assign io.out_rd    = rd_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed vector bench for alu_issue_stage.
// Vectors carry hand-computed expectations.
module tb_alu_issue_stage;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   alu_issue_stage_if #(
      .DATA_W(20), .OP_W(20), .AW(4)
   ) bus ();

   alu_issue_stage #(
      .DATA_W(20), .OP_W(20),
      .NREGS(16), .AW(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io (bus.slave)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [19:0] op;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic        ordy;
      logic        wen;
      logic [3:0]  wa;
      logic [19:0] wd;
      logic        crdy;
      logic        erdy;
      logic        eov;
      logic        cdat;
      logic [19:0] eop;
      logic [19:0] ea;
      logic [19:0] eb;
      logic [3:0]  erd;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(
      input string       name,
      input int          step,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h want %h",
                  name, step, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int s);
      @(negedge clk);
      rst           = v.rst;
      bus.in_valid  = v.iv;
      bus.in_op     = v.op;
      bus.in_rd     = v.rd;
      bus.in_rs1    = v.rs1;
      bus.in_rs2    = v.rs2;
      bus.out_ready = v.ordy;
      bus.wb_en     = v.wen;
      bus.wb_addr   = v.wa;
      bus.wb_data   = v.wd;
      #1;
      if (v.crdy)
         chk("in_ready", s,
             32'(bus.in_ready), 32'(v.erdy));
      @(posedge clk);
      #1;
      chk("out_valid", s,
          32'(bus.out_valid), 32'(v.eov));
      if (v.cdat) begin
         chk("out_op", s, 32'(bus.out_op), 32'(v.eop));
         chk("out_a", s, 32'(bus.out_a), 32'(v.ea));
         chk("out_b", s, 32'(bus.out_b), 32'(v.eb));
         chk("out_rd", s, 32'(bus.out_rd), 32'(v.erd));
      end
   endtask

   localparam int NV = 23;
   vec_t tv [NV];

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_rd     = '0;
      bus.in_rs1    = '0;
      bus.in_rs2    = '0;
      bus.out_ready = 1'b0;
      bus.wb_en     = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;

      // rst iv op rd rs1 rs2 ordy wen wa wd
      // crdy erdy eov cdat eop ea eb erd
      tv[0]  = '{1,0,20'h0,0,0,0,0,0,0,20'h0,
                 0,0,0,1,20'h0,20'h0,20'h0,0};
      tv[1]  = '{1,0,20'h0,0,0,0,0,0,0,20'h0,
                 1,1,0,1,20'h0,20'h0,20'h0,0};
      tv[2]  = '{0,0,20'h0,0,0,0,1,0,0,20'h0,
                 1,1,0,1,20'h0,20'h0,20'h0,0};
      tv[3]  = '{0,0,20'h0,0,0,0,1,1,1,20'h5,
                 1,1,0,0,20'h0,20'h0,20'h0,0};
      tv[4]  = '{0,0,20'h0,0,0,0,1,1,2,20'h3,
                 1,1,0,0,20'h0,20'h0,20'h0,0};
      tv[5]  = '{0,1,20'h169,3,1,2,1,0,0,20'h0,
                 1,1,1,1,20'h169,20'h5,20'h3,3};
      tv[6]  = '{0,1,20'haaaa,4,3,0,1,0,0,20'h0,
                 1,0,0,0,20'h0,20'h0,20'h0,0};
      tv[7]  = '{0,1,20'haaaa,4,3,0,1,0,0,20'h0,
                 1,0,0,0,20'h0,20'h0,20'h0,0};
      tv[8]  = '{0,1,20'haaaa,4,3,0,1,1,3,20'h8,
                 1,1,1,1,20'haaaa,20'h8,20'h0,4};
      tv[9]  = '{0,1,20'h12345,6,1,2,0,0,0,20'h0,
                 1,0,1,1,20'haaaa,20'h8,20'h0,4};
      tv[10] = '{0,1,20'h12345,6,1,2,0,0,0,20'h0,
                 1,0,1,1,20'haaaa,20'h8,20'h0,4};
      tv[11] = '{0,1,20'h12345,6,1,2,0,0,0,20'h0,
                 1,0,1,1,20'haaaa,20'h8,20'h0,4};
      tv[12] = '{0,1,20'h12345,6,1,2,1,0,0,20'h0,
                 1,1,1,1,20'h12345,20'h5,20'h3,6};
      tv[13] = '{0,0,20'h0,0,0,0,1,1,0,20'hfffff,
                 1,1,0,0,20'h0,20'h0,20'h0,0};
      tv[14] = '{0,1,20'h1,0,0,0,1,0,0,20'h0,
                 1,1,1,1,20'h1,20'h0,20'h0,0};
      tv[15] = '{0,1,20'h2,7,0,1,1,0,0,20'h0,
                 1,1,1,1,20'h2,20'h0,20'h5,7};
      tv[16] = '{0,1,20'h3,5,1,2,1,1,5,20'habcd,
                 1,1,1,1,20'h3,20'h5,20'h3,5};
      tv[17] = '{0,1,20'h4,8,5,0,1,0,0,20'h0,
                 1,0,0,0,20'h0,20'h0,20'h0,0};
      tv[18] = '{0,1,20'h4,8,5,0,1,0,0,20'h0,
                 1,0,0,0,20'h0,20'h0,20'h0,0};
      tv[19] = '{1,1,20'h4,8,5,0,1,0,0,20'h0,
                 1,0,0,1,20'h0,20'h0,20'h0,0};
      tv[20] = '{0,1,20'h4,8,5,0,1,0,0,20'h0,
                 1,1,1,1,20'h4,20'h0,20'h0,8};
      tv[21] = '{0,1,20'h5,9,0,2,1,1,2,20'h7,
                 1,1,1,1,20'h5,20'h0,20'h7,9};
      tv[22] = '{0,0,20'h0,0,0,0,1,0,0,20'h0,
                 1,1,0,0,20'h0,20'h0,20'h0,0};

      for (int i = 0; i < NV; i++)
         apply(tv[i], i);

      // Back-to-back issue, then RAW on the middle rd
      for (int k = 0; k < 3; k++)
         apply('{0,1,20'h10 + 20'(k),4'(10 + k),
                 2,0,1,0,0,20'h0,
                 1,1,1,1,20'h10 + 20'(k),20'h7,
                 20'h0,4'(10 + k)}, 100 + k);
      apply('{0,1,20'h20,13,11,0,1,0,0,20'h0,
              1,0,0,0,20'h0,20'h0,20'h0,0}, 103);
      apply('{0,1,20'h20,13,11,0,1,1,11,20'h55555,
              1,1,1,1,20'h20,20'h55555,20'h0,13},
            104);
      apply('{0,0,20'h0,0,0,0,1,0,0,20'h0,
              1,1,0,0,20'h0,20'h0,20'h0,0}, 105);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of the ALU.
- Holds the architectural register file and reads two source operands. Latches the 20-bit instruction code plus operands into a registered output that drives the ALU instruction/A/B inputs.
- Tracks in-flight destination writes with a scoreboard, stalling on read-after-write hazards. Accepts ALU results back through a writeback port.

Parameters:
- DATA_W, 20, operand/result width; matches the ALU datapath.
- OP_W, 20, instruction-code width; matches the ALU instruction input.
- NREGS, 16, number of registers; must be a power of 2 and at least 2.
- AW, 4, register index width; equals log2(NREGS).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  OP_W  instruction code, passed through unchanged.
- in_rd  in  AW  destination register index.
- in_rs1  in  AW  source index for A.
- in_rs2  in  AW  source index for B.
- out_valid  out  1  issued instruction is valid to the ALU.
- out_ready  in  1  ALU/downstream consumes the output this cycle.
- out_op  out  OP_W  drives ALU instruction.
- out_a  out  DATA_W  drives ALU A.
- out_b  out  DATA_W  drives ALU B.
- out_rd  out  AW  destination index, carried alongside for writeback.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback register index.
- wb_data  in  DATA_W  writeback value (ALU result).

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - out_valid=0; out_op, out_a, out_b and out_rd = 0.
  - All registers = 0; all scoreboard pending bits = 0.
  - Reset mid-stall or mid-hold discards the held instruction; no writeback is applied that cycle.
- Register 0 always reads 0, is never marked pending, and ignores writes.
- pend_eff[r] = pending[r] and not (wb_en and wb_addr==r). A writeback in the current cycle clears the hazard for that register in the same cycle.
- hazard = pend_eff[in_rs1] or pend_eff[in_rs2]. Both sources are always checked, including single-operand ops (NOT, INC, DEC).
- in_ready = (not out_valid or out_ready) and not hazard. in_ready is combinational and does not depend on in_valid.
- Accept = in_valid and in_ready. On accept, at the next edge:
  - out_valid=1 and out_op=in_op, out_rd=in_rd.
  - out_a and out_b take the register values, with bypass: if wb_en and wb_addr equals the source index (and that index is not 0), use wb_data.
  - pending[in_rd] is set to 1 unless in_rd=0.
- If out_valid and out_ready and not accept, then out_valid=0 next cycle.
- If out_valid and not out_ready, all out_* are held stable. Sources are read only at accept, never re-read while holding.
- Latency: one cycle from accept to out_valid. Throughput is one instruction per cycle when there is no hazard and out_ready=1.
- Writeback: when wb_en=1, regs[wb_addr]=wb_data and pending[wb_addr]=0. Index 0 is ignored.
- Same-cycle writeback and accept with wb_addr==in_rd: the set takes priority. pending stays 1 and the register value updates to wb_data.
- A writeback to a non-pending register is legal: the value is written and pending stays 0.
- Arithmetic: none; all paths are pure moves at DATA_W bits with no truncation or extension.

Test Plan:
- Reset then idle:
  - Stimulus: rst for 2 cycles.
  - Required: out_valid=0, in_ready=1, all out_* = 0.
- Basic issue:
  - Stimulus: wb r1=0x00005 and r2=0x00003; then issue op=0x00169, rd=3, rs1=1, rs2=2 with out_ready=1.
  - Required: next cycle out_valid=1, out_op=0x00169, out_a=0x00005, out_b=0x00003, out_rd=3; pending[3]=1.
- RAW stall:
  - Stimulus: after the basic issue, present rs1=3.
  - Required: in_ready=0 until wb_en with wb_addr=3, wb_data=0x00008.
  - Required: in that wb cycle in_ready=1, and on the following cycle out_a=0x00008 via bypass.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1, while upstream holds a new non-hazard instruction.
  - Required: out_* stable, in_ready=0. When out_ready returns to 1, the new instruction is accepted and appears the next cycle with no loss or duplication.
- Register zero:
  - Stimulus: wb r0=0xFFFFF, then issue rd=0, rs1=0, rs2=0.
  - Required: out_a=out_b=0; pending[0] is never set; a following rs1=0 instruction never stalls.
- Collision and reset:
  - Stimulus: issue rd=5 in the same cycle as wb_addr=5; next, present rs1=5.
  - Required: the rs1=5 instruction stalls. Then assert rst while stalled: out_valid=0 and all pending=0, so the rs1=5 instruction is accepted once rst deasserts.
